// File: rtl/deinterleaver.sv
// deinterleaver: receive-side 802.11a bit deinterleaver.
// Collects one OFDM symbol of N_CBPS hard bits into a ping-pong bank at the
// de-permuted address, then streams the bank out in natural order.
// Optional feature macro: DEINTERLEAVER_FRAME_EN adds Frame_Start and
// Symbol_Count outputs.
module deinterleaver #(
  parameter int N_CBPS = 192,
  parameter int N_BPSC = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Input,
  input  logic       Input_Valid,
  output logic       Output,
  output logic       Output_Valid
`ifdef DEINTERLEAVER_FRAME_EN
  ,
  output logic       Frame_Start,
  output logic [7:0] Symbol_Count
`endif
);

  localparam int AW = $clog2(N_CBPS);
  localparam int S  = (N_BPSC / 2 > 1) ? N_BPSC / 2 : 1;
  localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);

  typedef enum logic {IDLE, READ} rd_state_t;

  // Storage address for received bit j (both permutation steps inverted).
  function automatic logic [AW-1:0] addr_of(input int j);
    int i;
    int k;
    i = S * (j / S) + ((j + (16 * j) / N_CBPS) % S);
    k = 16 * i - (N_CBPS - 1) * ((16 * i) / N_CBPS);
    return AW'(k);
  endfunction

  // Elaboration-time address ROM, so no dividers exist at run time.
  logic [AW-1:0] wr_rom [N_CBPS];
  for (genvar g = 0; g < N_CBPS; g++) begin : g_rom
    assign wr_rom[g] = addr_of(g);
  end

  logic          mem_a [N_CBPS];
  logic          mem_b [N_CBPS];

  logic [AW-1:0] j_q, j_d;
  logic          wr_bank_q, wr_bank_d;
  rd_state_t     state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          pend_q, pend_d;
  logic          out_q, out_d;
  logic          vld_q, vld_d;
  logic          handoff;
  logic          rd_bit;
  logic [AW-1:0] wr_addr;

  assign handoff = Input_Valid && (j_q == LAST);
  assign wr_addr = wr_rom[j_q];
  assign rd_bit  = rd_bank_q ? mem_b[rd_addr_q] : mem_a[rd_addr_q];

  // Bank storage: each accepted bit lands at its de-permuted address.
  always_ff @(posedge Clock) begin
    if (Input_Valid) begin
      if (wr_bank_q) mem_b[wr_addr] <= Input;
      else           mem_a[wr_addr] <= Input;
    end
  end

  // Write side: count accepted bits, flip banks when a symbol completes.
  always_comb begin
    j_d       = j_q;
    wr_bank_d = wr_bank_q;
    if (Input_Valid) begin
      if (j_q == LAST) begin
        j_d       = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        j_d = j_q + AW'(1);
      end
    end
  end

  // Read side: stream a filled bank in natural order, chaining banks gaplessly.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    pend_d    = pend_q;
    out_d     = 1'b0;
    vld_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (handoff) begin
          state_d   = READ;
          rd_addr_d = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      READ: begin
        out_d = rd_bit;
        vld_d = 1'b1;
        if (rd_addr_q == LAST) begin
          if (handoff || pend_q) begin
            rd_addr_d = '0;
            rd_bank_d = ~rd_bank_q;
            pend_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
          if (handoff) pend_d = 1'b1;
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      j_q       <= '0;
      wr_bank_q <= 1'b0;
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      pend_q    <= 1'b0;
      out_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      j_q       <= j_d;
      wr_bank_q <= wr_bank_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
    end
  end

  assign Output       = out_q;
  assign Output_Valid = vld_q;

`ifdef DEINTERLEAVER_FRAME_EN
  logic       frame_q, frame_d;
  logic [7:0] cnt_q, cnt_d;

  // Frame marker on the k = 0 bit, symbol counter bumped at each handoff.
  always_comb begin
    frame_d = (state_q == READ) && (rd_addr_q == '0);
    cnt_d   = cnt_q + {7'd0, handoff};
  end

  // Frame marker and symbol counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      frame_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Frame_Start  = frame_q;
  assign Symbol_Count = cnt_q;
`endif

endmodule

// File: doc/deinterleaver.md
# deinterleaver

Receive-side bit deinterleaver for the 802.11a receiver chain: inverse of the transmitter's two-step block interleaver. Accepts the hard-decision coded bit stream from the demapper one bit per clock, collects one OFDM symbol of N_CBPS bits, and emits the bits in original (pre-interleave) order to the depuncturer/Viterbi decoder. Ping-pong buffered, so continuous back-to-back symbols stream without stalls.

## Interface
- N_CBPS, 192, coded bits per OFDM symbol (48, 96, 192, 288 legal)
- N_BPSC, 4, coded bits per subcarrier (1, 2, 4, 6); s = max(N_BPSC/2, 1)
- Clock  input  1  rising-edge clock, single domain
- Reset  input  1  asynchronous, active-low; assertion clears all state immediately
- Input  input  1  received coded bit, interleaved order
- Input_Valid  input  1  Input is sampled on a rising edge when high
- Output  output  1  deinterleaved bit, registered
- Output_Valid  output  1  high for each cycle Output carries a valid bit

## Operation
- Two banks A/B of N_CBPS bits each; write bank starts as A.
- Write side: counter j (0..N_CBPS-1) counts accepted bits. Received bit j is stored at address k where i = s*floor(j/s) + (j + floor(16*j/N_CBPS)) mod s, then k = 16*i - (N_CBPS-1)*floor(16*i/N_CBPS).
- Address mapping is a constant function of j: precompute it (elaboration-time ROM or incremental counters); no runtime dividers.
- On accepting j = N_CBPS-1: j wraps to 0, write bank toggles, the filled bank is handed to the read side.
- Read side states: IDLE -> READ on handoff; READ outputs addresses 0..N_CBPS-1, one per cycle, no backpressure; READ -> IDLE after address N_CBPS-1 unless another handoff is pending/coincident, in which case READ continues on the other bank with no gap cycle.
- Input gaps (Input_Valid low) only pause j; partial symbol is held indefinitely.
- Overrun cannot occur: writes are at most 1/cycle, so a bank is never rewritten before its read finishes; no overflow flag.
- Reset mid-symbol: partial symbol and any in-progress read discarded; bank contents need not be cleared.

## Timing
- Reset values: Output = 0, Output_Valid = 0, j = 0, write bank = A, read state IDLE.
- Latency: first output bit (k = 0) appears on Output with Output_Valid high one cycle after the edge that accepts the symbol's last input bit.
- Output_Valid then stays high exactly N_CBPS consecutive cycles per symbol; Output = 0 whenever Output_Valid is low.
- Continuous input (Input_Valid held high): Output_Valid stays high continuously from the first symbol's first output bit onward; end-to-end delay N_CBPS+1 cycles per bit position.
- Handoff and final read of previous symbol on the same edge: the new symbol's bit 0 follows the old symbol's bit N_CBPS-1 in the next cycle.

## Configuration
- DEINTERLEAVER_FRAME_EN defined: adds output port Frame_Start (1 bit, reset 0), high for exactly the cycle carrying bit k = 0 of each symbol, plus output Symbol_Count (8 bits, reset 0, wraps 255->0) incremented at each handoff.
- Undefined: neither port exists; remaining behaviour identical.

## Test plan
- Reset 1->0->1 mid-stream at bit 100 of a symbol -> Output=0, Output_Valid=0 immediately; next 192 valid inputs form a fresh symbol.
- N_CBPS=192, N_BPSC=4: feed 192-bit 110100111010101001100100... (the transmitter interleaver's output for input 111010111001101110110000...) -> Output reproduces 111010111001101110110000... all 192 bits, first bit one cycle after last input.
- Same vector streamed 3 times back-to-back -> Output_Valid high 576 consecutive cycles, each 192-bit block matches.
- Input_Valid toggled 1/0 every cycle -> identical output sequence; output burst still 192 contiguous cycles.
- N_CBPS=48, N_BPSC=1: single 1 at received position j=1 -> single 1 at output position k=16, all others 0.
- With DEINTERLEAVER_FRAME_EN: 2 symbols -> Frame_Start pulses exactly twice, 192 cycles apart; Symbol_Count ends at 2.
